// File: rtl/store_align_pkg.sv
// Shared types for the store-path aligner: size codes, FSM states, beat layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package store_align_pkg;

  // req_size encodings: log2 of the store width in bytes
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  // Beat layout for the default 32-bit data / 32-bit address build.
  // The aligner declares the same layout at its own parameter widths.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } beat_t;

  // Byte count of a store from its size code
  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/store_beat_fifo.sv
// Synchronous FIFO of memory write beats with registered count and flags.
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: pushes are ignored while full; full/empty come from the registered count only.
module store_beat_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         head_vld,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push_vld && !full;
  assign pop_ok   = pop_rdy && !empty;
  assign head_vld = !empty;
  // An empty FIFO presents all-zero beat fields
  assign head_dat = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are only observable through count, so no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_data_aligner.sv
// Store aligner: places store data on byte lanes with a write mask, splitting or rejecting word-crossing stores.
// Latency: beat 0 at the FIFO head one edge after acceptance; beat 1 of a split one edge later at the earliest.
// Backpressure: req_ready = IDLE && !full (registered only); mem_* held while mem_valid && !mem_ready.
module store_data_aligner
  import store_align_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int DEPTH          = 2,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [1:0]            req_size,
  input  logic [DATA_W-1:0]     req_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  err,
  output logic                  busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BYTES-1:0]  we;
    logic [DATA_W-1:0] wdata;
  } beat_w_t;

  state_t              state, state_nxt;
  beat_w_t             hold, beat0, beat1, push_dat, head;
  logic                push_vld, hold_ld, full, empty, head_vld;
  logic                accept, crossing, oversize, legal;
  logic [OFF_W-1:0]    off;
  logic [31:0]         off_ext, n_ext;
  logic [BYTES-1:0]    lo_we;
  logic [DATA_W-1:0]   dmask;
  logic [2*BYTES-1:0]  wide_we;
  logic [2*DATA_W-1:0] wide_data;
  logic [ADDR_W-1:0]   addr0;

  assign off      = req_addr[OFF_W-1:0];
  assign off_ext  = 32'(off);
  assign n_ext    = 32'(size_bytes(req_size));
  assign oversize = n_ext > 32'(BYTES);
  assign crossing = (off_ext + n_ext) > 32'(BYTES);
  assign legal    = !oversize && !(crossing && (ALLOW_MISALIGN == 1'b0));

  assign req_ready = (state == IDLE) && !full;
  assign accept    = req_valid && req_ready;

  // Lane enables and data keep-mask for the low n bytes of the request
  always_comb begin
    lo_we = '0;
    dmask = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (32'(i) < n_ext) begin
        lo_we[i]        = 1'b1;
        dmask[8*i +: 8] = 8'hFF;
      end
    end
  end

  assign wide_we   = {{BYTES{1'b0}}, lo_we} << off;
  assign wide_data = {{DATA_W{1'b0}}, req_data & dmask} << {off, 3'b000};
  assign addr0     = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign beat0 = '{addr: addr0, we: wide_we[BYTES-1:0], wdata: wide_data[DATA_W-1:0]};
  assign beat1 = '{addr: addr0 + ADDR_W'(BYTES), we: wide_we[2*BYTES-1:BYTES],
                   wdata: wide_data[2*DATA_W-1:DATA_W]};

  // State, held second beat and the error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hold_ld) hold <= beat1;
      err <= accept && !legal;
    end
  end

  // Next state and FIFO push selection
  always_comb begin
    state_nxt = state;
    push_vld  = 1'b0;
    push_dat  = beat0;
    hold_ld   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && legal) begin
          push_vld = 1'b1;
          if (crossing) begin
            hold_ld   = 1'b1;
            state_nxt = SPLIT;
          end
        end
      end
      SPLIT: begin
        if (!full) begin
          push_vld  = 1'b1;
          push_dat  = hold;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  store_beat_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(beat_w_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (mem_ready),
    .head_vld (head_vld),
    .head_dat (head),
    .full     (full),
    .empty    (empty)
  );

  assign mem_valid = head_vld;
  assign mem_addr  = head.addr;
  assign mem_we    = head.we;
  assign mem_wdata = head.wdata;
  assign busy      = (state != IDLE) || !empty;

endmodule

// File: tb/tb_store_data_aligner.sv
// Bench for store_data_aligner: directed table, corner sequences and a randomized stream.
// Three instances: default 32-bit, 32-bit with misalignment rejected, 64-bit.
// Expected beats come from a byte-by-byte address model, not from shifting.
module tb_store_data_aligner;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } tb_beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    int          nb;
    tb_beat_t    b0;
    tb_beat_t    b1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        req_valid = 1'b0, req_ready, mem_valid, mem_ready = 1'b1, err, busy;
  logic [31:0] req_addr = '0, req_data = '0, mem_addr, mem_wdata;
  logic [1:0]  req_size = '0;
  logic [3:0]  mem_we;

  // Misalignment-rejecting instance
  logic        n_req_valid = 1'b0, n_req_ready, n_mem_valid, n_mem_ready = 1'b1, n_err, n_busy;
  logic [31:0] n_req_addr = '0, n_req_data = '0, n_mem_addr, n_mem_wdata;
  logic [1:0]  n_req_size = '0;
  logic [3:0]  n_mem_we;

  // 64-bit instance
  logic        w_req_valid = 1'b0, w_req_ready, w_mem_valid, w_mem_ready = 1'b1, w_err, w_busy;
  logic [31:0] w_req_addr = '0, w_mem_addr;
  logic [63:0] w_req_data = '0, w_mem_wdata;
  logic [1:0]  w_req_size = '0;
  logic [7:0]  w_mem_we;

  store_data_aligner #(.DATA_W(32), .ADDR_W(32), .DEPTH(2), .ALLOW_MISALIGN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .err(err), .busy(busy));

  store_data_aligner #(.DATA_W(32), .ADDR_W(32), .DEPTH(2), .ALLOW_MISALIGN(1'b0)) u_nomis (
    .clk(clk), .rst_n(rst_n), .req_valid(n_req_valid), .req_ready(n_req_ready),
    .req_addr(n_req_addr), .req_size(n_req_size), .req_data(n_req_data),
    .mem_valid(n_mem_valid), .mem_ready(n_mem_ready), .mem_addr(n_mem_addr),
    .mem_we(n_mem_we), .mem_wdata(n_mem_wdata), .err(n_err), .busy(n_busy));

  store_data_aligner #(.DATA_W(64), .ADDR_W(32), .DEPTH(2), .ALLOW_MISALIGN(1'b1)) u_d64 (
    .clk(clk), .rst_n(rst_n), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_addr(w_req_addr), .req_size(w_req_size), .req_data(w_req_data),
    .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_addr(w_mem_addr),
    .mem_we(w_mem_we), .mem_wdata(w_mem_wdata), .err(w_err), .busy(w_busy));

  int       tests = 0;
  int       fails = 0;
  int       err_seen = 0;
  bit       rnd_bp = 1'b0;
  tb_beat_t obs_q[$];
  tb_beat_t exp_q[$];
  tb_beat_t mon_b;

  // Record every completed beat handshake and every err cycle of the default instance
  always @(negedge clk) begin
    if (mem_valid && mem_ready) begin
      mon_b.addr  = mem_addr;
      mon_b.we    = mem_we;
      mon_b.wdata = mem_wdata;
      obs_q.push_back(mon_b);
    end
    if (err) err_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock step; inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_bp) mem_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present a request until accepted (bounded); returns after the accepting edge
  task automatic send(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d, output bit ok);
    req_addr  = a;
    req_size  = s;
    req_data  = d;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    if (!ok) chk("req_accept_timeout", 64'd0, 64'd1);
  endtask

  // Reference: every byte k of the store goes to address a+k; beat 0 owns the
  // aligned word containing a, anything else lands in the following word.
  function automatic void model(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                                output bit legal, output int nb,
                                output tb_beat_t b0, output tb_beat_t b1);
    int          n;
    logic [31:0] base;
    logic [31:0] ba;
    int          lane;
    n     = 1 << s;
    base  = a & 32'hFFFF_FFFC;
    b0    = '0;
    b1    = '0;
    b0.addr = base;
    b1.addr = base + 32'd4;
    legal = (n <= 4);
    nb    = 0;
    if (!legal) return;
    nb = 1;
    for (int k = 0; k < n; k++) begin
      ba   = a + 32'(k);
      lane = int'(ba % 4);
      if ((ba & 32'hFFFF_FFFC) == base) begin
        b0.we[lane] = 1'b1;
        b0.wdata[8*lane +: 8] = d[8*k +: 8];
      end else begin
        b1.we[lane] = 1'b1;
        b1.wdata[8*lane +: 8] = d[8*k +: 8];
        nb = 2;
      end
    end
  endfunction

  function automatic vec_t mkv(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d, input int nb,
                               input logic [31:0] a0, input logic [3:0] we0, input logic [31:0] d0,
                               input logic [31:0] a1, input logic [3:0] we1, input logic [31:0] d1);
    vec_t v;
    v.addr = a; v.size = s; v.data = d; v.nb = nb;
    v.b0.addr = a0; v.b0.we = we0; v.b0.wdata = d0;
    v.b1.addr = a1; v.b1.we = we1; v.b1.wdata = d1;
    return v;
  endfunction

  vec_t vt[8];

  initial begin
    bit       ok, legal;
    int       nb, exp_err;
    tb_beat_t b0, b1;
    tb_beat_t ha;
    logic [31:0] ra, rd;
    logic [1:0]  rs;

    vt[0] = mkv(32'h100, 2'd2, 32'hDEADBEEF, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 0, 0);
    vt[1] = mkv(32'h103, 2'd0, 32'hFFFFFFAB, 1, 32'h100, 4'b1000, 32'hAB000000, 0, 0, 0);
    vt[2] = mkv(32'h101, 2'd1, 32'hAAAA1234, 1, 32'h100, 4'b0110, 32'h00123400, 0, 0, 0);
    vt[3] = mkv(32'h102, 2'd2, 32'h11223344, 2, 32'h100, 4'b1100, 32'h33440000, 32'h104, 4'b0011, 32'h00001122);
    vt[4] = mkv(32'hFFFFFFFE, 2'd2, 32'h11223344, 2, 32'hFFFFFFFC, 4'b1100, 32'h33440000, 32'h0, 4'b0011, 32'h00001122);
    vt[5] = mkv(32'h107, 2'd1, 32'h5555BEEF, 2, 32'h104, 4'b1000, 32'hEF000000, 32'h108, 4'b0001, 32'h000000BE);
    vt[6] = mkv(32'h202, 2'd0, 32'h12345678, 1, 32'h200, 4'b0100, 32'h00780000, 0, 0, 0);
    vt[7] = mkv(32'h104, 2'd1, 32'h0000CAFE, 1, 32'h104, 4'b0011, 32'h0000CAFE, 0, 0, 0);

    // Reset state
    #12;
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Directed table, downstream always ready
    for (int i = 0; i < 8; i++) begin
      obs_q.delete();
      err_seen = 0;
      send(vt[i].addr, vt[i].size, vt[i].data, ok);
      chk($sformatf("v%0d_head_valid", i), 64'(mem_valid), 64'd1);
      chk($sformatf("v%0d_head_addr", i), 64'(mem_addr), 64'(vt[i].b0.addr));
      chk($sformatf("v%0d_ready_after", i), 64'(req_ready), (vt[i].nb == 2) ? 64'd0 : 64'd1);
      tick();
      chk($sformatf("v%0d_ready_next", i), 64'(req_ready), 64'd1);
      repeat (5) tick();
      chk($sformatf("v%0d_nbeats", i), 64'(obs_q.size()), 64'(vt[i].nb));
      if (obs_q.size() >= 1) chk($sformatf("v%0d_beat0", i), 64'(obs_q[0]), 64'(vt[i].b0));
      if (obs_q.size() >= 2) chk($sformatf("v%0d_beat1", i), 64'(obs_q[1]), 64'(vt[i].b1));
      chk($sformatf("v%0d_no_err", i), 64'(err_seen), 64'd0);
    end

    // Double store on a 32-bit path: one-cycle err, nothing emitted
    obs_q.delete();
    send(32'h100, 2'd3, 32'h12345678, ok);
    chk("sd32_err_pulse", 64'(err), 64'd1);
    tick();
    chk("sd32_err_clear", 64'(err), 64'd0);
    repeat (3) tick();
    chk("sd32_no_beat", 64'(obs_q.size()), 64'd0);
    chk("sd32_idle", 64'(busy), 64'd0);

    // Backpressure: two aligned stores fill the FIFO, head holds, then ordered drain
    obs_q.delete();
    mem_ready = 1'b0;
    send(32'h200, 2'd2, 32'hA0A0A0A0, ok);
    send(32'h204, 2'd2, 32'hB1B1B1B1, ok);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    ha.addr = mem_addr; ha.we = mem_we; ha.wdata = mem_wdata;
    chk("bp_head_addr", 64'(ha.addr), 64'h200);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_head_stable", 64'({mem_addr, mem_we, mem_wdata}), 64'(ha));
      chk("bp_ready_still_low", 64'(req_ready), 64'd0);
    end
    mem_ready = 1'b1;
    send(32'h208, 2'd2, 32'hC2C2C2C2, ok);
    repeat (5) tick();
    chk("bp_drain_count", 64'(obs_q.size()), 64'd3);
    for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
      chk("bp_drain_addr", 64'(obs_q[k].addr), 64'(32'h200 + 32'(4 * k)));
      chk("bp_drain_we", 64'(obs_q[k].we), 64'hF);
    end
    if (obs_q.size() == 3) chk("bp_drain_data2", 64'(obs_q[2].wdata), 64'hC2C2C2C2);

    // Misalignment rejected: err pulse and no beat
    n_req_addr = 32'h102; n_req_size = 2'd2; n_req_data = 32'h11223344; n_req_valid = 1'b1;
    @(negedge clk);
    chk("nomis_ready", 64'(n_req_ready), 64'd1);
    tick();
    n_req_valid = 1'b0;
    chk("nomis_err_pulse", 64'(n_err), 64'd1);
    chk("nomis_no_valid", 64'(n_mem_valid), 64'd0);
    tick();
    chk("nomis_err_clear", 64'(n_err), 64'd0);
    chk("nomis_no_valid2", 64'(n_mem_valid), 64'd0);
    chk("nomis_idle", 64'(n_busy), 64'd0);

    // 64-bit path: double store and a top-lane byte
    w_req_addr = 32'h100; w_req_size = 2'd3; w_req_data = 64'h0123456789ABCDEF; w_req_valid = 1'b1;
    @(negedge clk);
    chk("d64_ready", 64'(w_req_ready), 64'd1);
    tick();
    w_req_addr = 32'h107; w_req_size = 2'd0; w_req_data = 64'hFFFFFFFFFFFFFF5A;
    chk("d64_sd_valid", 64'(w_mem_valid), 64'd1);
    chk("d64_sd_we", 64'(w_mem_we), 64'hFF);
    chk("d64_sd_wdata", w_mem_wdata, 64'h0123456789ABCDEF);
    chk("d64_sd_addr", 64'(w_mem_addr), 64'h100);
    tick();
    w_req_valid = 1'b0;
    chk("d64_sb_we", 64'(w_mem_we), 64'h80);
    chk("d64_sb_wdata", w_mem_wdata, 64'h5A00000000000000);
    chk("d64_no_err", 64'(w_err), 64'd0);
    repeat (2) tick();

    // Randomized stream against the byte model, with random downstream stalls
    obs_q.delete();
    exp_q.delete();
    err_seen = 0;
    exp_err = 0;
    rnd_bp = 1'b1;
    for (int r = 0; r < 300; r++) begin
      ra = $urandom();
      rs = 2'($urandom_range(0, 3));
      rd = $urandom();
      model(ra, rs, rd, legal, nb, b0, b1);
      send(ra, rs, rd, ok);
      if (ok) begin
        if (!legal) exp_err++;
        if (nb >= 1) exp_q.push_back(b0);
        if (nb == 2) exp_q.push_back(b1);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd_bp = 1'b0;
    mem_ready = 1'b1;
    repeat (10) tick();
    chk("rnd_beat_count", 64'(obs_q.size()), 64'(exp_q.size()));
    chk("rnd_err_count", 64'(err_seen), 64'(exp_err));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      chk($sformatf("rnd_beat%0d", k), 64'(obs_q[k]), 64'(exp_q[k]));

    // Reset while splitting with the FIFO full: held beat 1 must never appear
    mem_ready = 1'b0;
    send(32'h300, 2'd2, 32'h01020304, ok);
    send(32'h302, 2'd2, 32'h55667788, ok);
    chk("mid_split_busy", 64'(busy), 64'd1);
    chk("mid_split_ready", 64'(req_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_valid", 64'(mem_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_mem_we", 64'(mem_we), 64'd0);
    chk("arst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("arst_mem_addr", 64'(mem_addr), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    obs_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_ready = 1'b1;
    chk("arst_release_ready", 64'(req_ready), 64'd1);
    repeat (8) tick();
    chk("arst_no_stale_beat", 64'(obs_q.size()), 64'd0);
    send(32'h400, 2'd2, 32'hFEEDFACE, ok);
    repeat (3) tick();
    chk("arst_recover_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() == 1) chk("arst_recover_beat", 64'(obs_q[0]), {28'd0, 32'h400, 4'hF} << 32 | 64'hFEEDFACE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
